approx_mult_sweep_ctrl: RTL
===========================

// Module: approx_mult_sweep_ctrl
// PURPOSE
//  Self-test sequencer for the 4x4 approximate multiplier datapath (approximate_multiplier_4x4).
//  On start, it drives every (A,B) operand pair into the multiplier and compares each P with the exact A*B.
//  It accumulates error statistics and reports them with a done pulse.
//  Sits beside the multiplier as its on-chip characterisation engine; replaces the offline exhaustive sweep.
// PARAMETERS
//  OP_W   4        operand width; sweep covers 2^(2*OP_W) pairs
//  P_W    2*OP_W   product width (mult_p, exact product, max_err)
//  SUM_W  4*OP_W   err_sum width; guarantees no overflow (2^(2W) pairs x <2^(2W) error)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      sweep request, sampled in IDLE only
//  abort     in   1      synchronous abort, sampled while busy
//  mult_a    out  OP_W   operand A to multiplier (registered)
//  mult_b    out  OP_W   operand B to multiplier (registered)
//  mult_p    in   P_W    multiplier product (combinational from mult_a/mult_b)
//  busy      out  1      sweep in progress
//  done      out  1      one-cycle pulse, sweep complete
//  res_valid out  1      statistics valid (set with done, cleared by start/abort/rst)
//  err_sum   out  SUM_W  sum of |P - A*B| over all pairs
//  err_cnt   out  2*OP_W+1  number of pairs with P != A*B
//  max_err   out  P_W    largest |P - A*B| seen
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pair index 0. Reset mid-sweep aborts silently; no done is issued.
//  - FSM: IDLE -> SWEEP -> DRAIN -> IDLE.
//    - IDLE & start: clear err_sum/err_cnt/max_err/res_valid, idx<=0, {mult_a,mult_b}<=0, busy<=1, go to SWEEP.
//    - SWEEP: each edge registers mult_p plus exact product of current mult_a*mult_b into stage reg (s_vld=1).
//      It then advances {mult_a,mult_b}<={a,b}+1; A is the high half of idx and B the low half.
//      After pair 2^(2W)-1 is sampled, go to DRAIN; the operand counter does not wrap-advance further.
//    - DRAIN: final stage reg accumulated; busy<=0, done<=1, res_valid<=1, go to IDLE.
//  - Accumulate stage (one edge after sample, when s_vld): d=|p_q-exact_q| computed unsigned, no wrap.
//    - err_sum+=d.
//    - err_cnt+=(d!=0).
//    - max_err=max(max_err,d).
//  - Timing (W=4): start sampled at edge T0; pair n sampled at edge T(n+1); done high after edge T257 for exactly 1 cycle; busy high T0..T257.
//  - start while busy: ignored. start in same cycle done is high: accepted (state already IDLE on next edge only; i.e. start at edge T258 or later).
//  - abort while busy: next edge -> IDLE, busy<=0, res_valid stays 0, no done, partial stats hold until next start.
//  - abort and start together in IDLE: abort ignored, start taken.
//  - Statistics hold stable from done until next start or rst.
// STRUCTURE
//  - Shared package: FSM state encoding (ST_IDLE/ST_SWEEP/ST_DRAIN), OP_W default, SUM_W derivation.
//  - One natural sub-module: approx_err_accum (stage reg + |diff| + sum/cnt/max registers).
//  - Multiplier is external to keep the sequencer reusable across approximation variants.
// TESTING (bench instantiates a stub or approximate_multiplier_4x4 on mult_a/mult_b/mult_p)
//  1. Exact stub P=A*B, start -> done after edge T257, err_sum=0, err_cnt=0, max_err=0, res_valid=1.
//  2. Stub P=(A*B)&8'hFE -> err_sum=64, err_cnt=64 (both odd), max_err=1.
//  3. Stub P=0 -> err_sum=14400, err_cnt=225, max_err=225.
//  4. Exact stub, pulse start again at T50 and T120 -> ignored; single done at T257, stats as in test 1.
//  5. Stub P=0, abort at T100 -> busy=0 at T101, no done, res_valid=0. Then start -> full result as in test 3.
//  6. rst asserted async at T80 -> outputs 0 immediately, IDLE. start after release -> correct sweep.
//  Also: run approximate_multiplier_4x4 and check err_sum/err_cnt against the software exhaustive model.

Source files
------------

// File: rtl/approx_mult_sweep_ctrl_pkg.sv
// Shared definitions for the approximate-multiplier sweep controller:
// FSM encoding, default operand width and statistics width derivation.
package approx_mult_sweep_ctrl_pkg;

  localparam int OP_W_DEF = 4;

  // err_sum must hold 2^(2W) pairs each contributing an error below 2^(2W).
  function automatic int sum_w(input int op_w);
    return 4 * op_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/approx_mult_sweep_ctrl_err_accum.sv
// Error accumulator: stages (P, exact A*B) for one cycle, then folds
// |P - A*B| into the running sum, mismatch count and maximum.
module approx_err_accum #(
  parameter int OP_W  = 4,
  parameter int P_W   = 2 * OP_W,
  parameter int SUM_W = 4 * OP_W,
  parameter int CNT_W = 2 * OP_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [P_W-1:0]   p,
  output logic [SUM_W-1:0] err_sum,
  output logic [CNT_W-1:0] err_cnt,
  output logic [P_W-1:0]   max_err
);

  logic             s_vld;
  logic [P_W-1:0]   p_q;
  logic [P_W-1:0]   exact_q;
  logic [P_W-1:0]   diff;
  logic [P_W-1:0]   exact;

  assign exact = P_W'(a) * P_W'(b);
  // Magnitude taken by ordered subtraction so the unsigned result never wraps.
  assign diff  = (p_q >= exact_q) ? (p_q - exact_q) : (exact_q - p_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld   <= 1'b0;
      p_q     <= '0;
      exact_q <= '0;
      err_sum <= '0;
      err_cnt <= '0;
      max_err <= '0;
    end else if (clear) begin
      s_vld   <= 1'b0;
      p_q     <= '0;
      exact_q <= '0;
      err_sum <= '0;
      err_cnt <= '0;
      max_err <= '0;
    end else begin
      s_vld   <= sample;
      p_q     <= p;
      exact_q <= exact;
      if (s_vld) begin
        err_sum <= err_sum + {{(SUM_W-P_W){1'b0}}, diff};
        err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, (diff != '0)};
        if (diff > max_err) max_err <= diff;
      end
    end
  end

endmodule

// File: rtl/approx_mult_sweep_ctrl.sv
// Self-test sequencer: walks every (A,B) pair through an external multiplier
// and reports accumulated error statistics with a one-cycle done pulse.
module approx_mult_sweep_ctrl
  import approx_mult_sweep_ctrl_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int P_W   = 2 * OP_W,
  parameter int SUM_W = sum_w(OP_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [OP_W-1:0]   mult_a,
  output logic [OP_W-1:0]   mult_b,
  input  logic [P_W-1:0]    mult_p,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic [SUM_W-1:0]  err_sum,
  output logic [2*OP_W:0]   err_cnt,
  output logic [P_W-1:0]    max_err,
  output state_t            state
);

  logic [2*OP_W-1:0] idx;
  logic              sample;
  logic              clear;

  // A is the high half of the pair index, B the low half.
  assign mult_a = idx[2*OP_W-1:OP_W];
  assign mult_b = idx[OP_W-1:0];
  assign sample = (state == ST_SWEEP);
  assign clear  = (state == ST_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= '0;
            busy      <= 1'b1;
            res_valid <= 1'b0;
            state     <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (idx == '1) begin
            state <= ST_DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (!abort) begin
            done      <= 1'b1;
            res_valid <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  approx_err_accum #(
    .OP_W  (OP_W),
    .P_W   (P_W),
    .SUM_W (SUM_W),
    .CNT_W (2*OP_W+1)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .sample  (sample),
    .a       (mult_a),
    .b       (mult_b),
    .p       (mult_p),
    .err_sum (err_sum),
    .err_cnt (err_cnt),
    .max_err (max_err)
  );

endmodule
